// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs load data) onto the single RF write port; optional pending-write scoreboard under RF_SCOREBOARD_EN.
// Latency: one cycle from valid&ready to rf_ld/rf_c/rf_pc; readies are combinational.
// Backpressure: hold or losing arbitration deasserts ready, and the source keeps rd/data stable until granted.
module rf_wb_arbiter #(
   parameter int DW   = 32,
   parameter int AW   = 4,
   parameter int NREG = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [DW-1:0]   alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [AW-1:0]   mem_rd,
   input  logic [DW-1:0]   mem_data,
   input  logic            hold,
   output logic            rf_ld,
   output logic [AW-1:0]   rf_c,
   output logic [DW-1:0]   rf_pc,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_ready,
   output logic [NREG-1:0] busy,
   output logic            sb_err
);

   typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} pri_e;

   pri_e            pri_q, pri_d;
   logic            rf_ld_q, rf_ld_d;
   logic [AW-1:0]   rf_c_q, rf_c_d;
   logic [DW-1:0]   rf_pc_q, rf_pc_d;
   logic            grant_alu, grant_mem;

   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      pri_d     = pri_q;
      rf_ld_d   = 1'b0;
      rf_c_d    = rf_c_q;
      rf_pc_d   = rf_pc_q;
      if (!hold) begin
         if (alu_valid && (!mem_valid || pri_q == PRI_ALU)) begin
            grant_alu = 1'b1;
         end else if (mem_valid) begin
            grant_mem = 1'b1;
         end
      end
      // The granted source loses priority for the next contention.
      if (grant_alu) begin
         pri_d   = PRI_MEM;
         rf_ld_d = 1'b1;
         rf_c_d  = alu_rd;
         rf_pc_d = alu_data;
      end else if (grant_mem) begin
         pri_d   = PRI_ALU;
         rf_ld_d = 1'b1;
         rf_c_d  = mem_rd;
         rf_pc_d = mem_data;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pri_q   <= PRI_ALU;
         rf_ld_q <= 1'b0;
         rf_c_q  <= '0;
         rf_pc_q <= '0;
      end else begin
         pri_q   <= pri_d;
         rf_ld_q <= rf_ld_d;
         rf_c_q  <= rf_c_d;
         rf_pc_q <= rf_pc_d;
      end
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;
   assign rf_ld     = rf_ld_q;
   assign rf_c      = rf_c_q;
   assign rf_pc     = rf_pc_q;

`ifdef RF_SCOREBOARD_EN
   logic [NREG-1:0] busy_q, busy_d;
   logic            sb_err_q, sb_err_d;

   always_comb begin
      busy_d   = busy_q;
      sb_err_d = rf_ld_q && !busy_q[rf_c_q];
      if (rf_ld_q) begin
         busy_d[rf_c_q] = 1'b0;
      end
      // Applied after the clear so a same-edge reservation survives.
      if (iss_valid && !busy_q[iss_rd]) begin
         busy_d[iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         busy_q   <= '0;
         sb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         sb_err_q <= sb_err_d;
      end
   end

   assign iss_ready = ~busy_q[iss_rd];
   assign busy      = busy_q;
   assign sb_err    = sb_err_q;
`else
   logic unused_iss;
   assign unused_iss = ^{iss_valid, iss_rd};
   assign iss_ready  = 1'b1;
   assign busy       = '0;
   assign sb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic against a reference model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 4;
   localparam int NREG = 16;
`ifdef RF_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RESET;
   logic            alu_valid, alu_ready;
   logic [AW-1:0]   alu_rd;
   logic [DW-1:0]   alu_data;
   logic            mem_valid, mem_ready;
   logic [AW-1:0]   mem_rd;
   logic [DW-1:0]   mem_data;
   logic            hold;
   logic            rf_ld;
   logic [AW-1:0]   rf_c;
   logic [DW-1:0]   rf_pc;
   logic            iss_valid, iss_ready;
   logic [AW-1:0]   iss_rd;
   logic [NREG-1:0] busy;
   logic            sb_err;

   always #5 CLK = ~CLK;

   rf_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .CLK(CLK), .RESET(RESET),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .hold(hold), .rf_ld(rf_ld), .rf_c(rf_c), .rf_pc(rf_pc),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .busy(busy), .sb_err(sb_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: who wins a tie, what the RF port shows, which registers are reserved.
   bit              m_alu_first;
   bit              m_ld;
   logic [AW-1:0]   m_c;
   logic [DW-1:0]   m_pc;
   logic [NREG-1:0] m_busy;
   bit              m_err;
   bit              e_ar, e_mr, e_ir;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_alu_first = 1'b1;
      m_ld        = 1'b0;
      m_c         = '0;
      m_pc        = '0;
      m_busy      = '0;
      m_err       = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_rf_ld"}, rf_ld, m_ld);
      chk({tag, "_rf_c"}, rf_c, m_c);
      chk({tag, "_rf_pc"}, rf_pc, m_pc);
      chk({tag, "_busy"}, busy, m_busy);
      chk({tag, "_sb_err"}, sb_err, m_err);
   endtask

   task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        input bit h, input bit iv, input logic [AW-1:0] ird);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      hold = h; iss_valid = iv; iss_rd = ird;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: check readies mid-cycle, predict the edge, check registered outputs after it.
   task automatic cycle(input string tag);
      logic [NREG-1:0] nb;
      logic [AW-1:0]   nc;
      logic [DW-1:0]   npc;
      bit              nld, nerr, nfirst;
      #1;
      e_ar = !hold && alu_valid && (!mem_valid || m_alu_first);
      e_mr = !hold && mem_valid && !e_ar;
      e_ir = SB ? !m_busy[iss_rd] : 1'b1;
      chk({tag, "_alu_ready"}, alu_ready, e_ar);
      chk({tag, "_mem_ready"}, mem_ready, e_mr);
      chk({tag, "_iss_ready"}, iss_ready, e_ir);
      nld = e_ar || e_mr;
      nc = m_c; npc = m_pc; nfirst = m_alu_first;
      if (e_ar) begin
         nc = alu_rd; npc = alu_data; nfirst = 1'b0;
      end else if (e_mr) begin
         nc = mem_rd; npc = mem_data; nfirst = 1'b1;
      end
      nb = m_busy; nerr = 1'b0;
      if (SB) begin
         nerr = m_ld && !m_busy[m_c];
         if (m_ld) nb[m_c] = 1'b0;
         if (iss_valid && e_ir) nb[iss_rd] = 1'b1;
      end
      @(posedge CLK);
      #1;
      m_ld = nld; m_c = nc; m_pc = npc; m_alu_first = nfirst; m_busy = nb; m_err = nerr;
      check_regs(tag);
   endtask

   initial begin
      int k;
      logic [AW-1:0] t3_exp [4];
      RESET = 1'b0;
      idle();
      model_reset();
      #3;
      check_regs("por");
      @(posedge CLK);
      #1;
      RESET = 1'b1;

      // 1: reset lands between a transfer and its commit
      drive(1, 4, 32'h1111_0004, 0, 0, 0, 0, 1, 4);
      cycle("t1a");
      drive(1, 6, 32'h1111_0006, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t1_alu_ready_pre", alu_ready, 1'b1);
      #1;
      RESET = 1'b0;
      model_reset();
      #1;
      check_regs("t1_async");
      @(posedge CLK);
      #1;
      check_regs("t1_held");
      RESET = 1'b1;
      drive(1, 8, 32'h2222_0008, 1, 10, 32'h3333_000A, 0, 0, 0);
      cycle("t1_pri");
      chk("t1_alu_won", rf_c, 8);

      // 2: single ALU write
      drive(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      cycle("t2");
      chk("t2_ld", rf_ld, 1'b1);
      chk("t2_c", rf_c, 3);
      chk("t2_pc", rf_pc, 32'hDEAD_BEEF);
      drive(0, 0, 0, 1, 0, 32'h0000_0F0F, 0, 0, 0);
      cycle("t2_mem");

      // 3: sustained contention alternates
      t3_exp[0] = 1; t3_exp[1] = 2; t3_exp[2] = 1; t3_exp[3] = 2;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 32'hA000_0000 + i, 1, 2, 32'hB000_0000 + i, 0, 0, 0);
         cycle("t3");
         chk("t3_rf_c", rf_c, t3_exp[i]);
         chk("t3_ld", rf_ld, 1'b1);
      end

      // 4: hold blocks everything and preserves priority
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'hC000_0001, 1, 2, 32'hC000_0002, 1, 0, 0);
         cycle("t4_hold");
         chk("t4_ld_low", rf_ld, 1'b0);
      end
      drive(1, 1, 32'hC000_0001, 1, 2, 32'hC000_0002, 0, 0, 0);
      cycle("t4_rel");
      chk("t4_alu_first", rf_c, 1);

      // 5: reservation, refused re-reservation, clear after commit
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5);
      cycle("t5_iss");
      chk("t5_busy_set", busy[5], SB);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5);
      cycle("t5_reiss");
      drive(0, 0, 0, 1, 5, 32'h5555_5555, 0, 0, 0);
      cycle("t5_wr");
      idle();
      cycle("t5_clr");
      chk("t5_busy_clr", busy[5], 1'b0);
      chk("t5_no_err", sb_err, 1'b0);

      // 6: same-edge set/clear, then an unreserved write
      drive(1, 7, 32'h7777_7777, 0, 0, 0, 0, 0, 0);
      cycle("t6_wr7");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
      cycle("t6_iss7");
      chk("t6_busy7", busy[7], SB);
      idle();
      cycle("t6_idle");
      drive(1, 9, 32'h9999_9999, 0, 0, 0, 0, 0, 0);
      cycle("t6_wr9");
      idle();
      cycle("t6_err");
      chk("t6_err_pulse", sb_err, SB);
      cycle("t6_err_end");
      chk("t6_err_gone", sb_err, 1'b0);

      // Random traffic; a stalled request keeps its rd/data until granted.
      for (k = 0; k < 400; k++) begin
         if (!(alu_valid && !e_ar)) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = AW'($urandom_range(0, NREG - 1));
            alu_data  = $urandom;
         end
         if (!(mem_valid && !e_mr)) begin
            mem_valid = ($urandom_range(0, 2) != 0);
            mem_rd    = AW'($urandom_range(0, NREG - 1));
            mem_data  = $urandom;
         end
         hold      = ($urandom_range(0, 7) == 0);
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_rd    = AW'($urandom_range(0, NREG - 1));
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
